// File: rtl/sonar_range.sv
// Six-channel sonar range converter: one shared restoring divider
// serves channels 1..6 round-robin and saturates each distance.
module sonar_range #(
    parameter int IN_W    = 20,
    parameter int DIVISOR = 2941,
    parameter int OUT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [IN_W-1:0]      R1,
    input  logic [IN_W-1:0]      R2,
    input  logic [IN_W-1:0]      R3,
    input  logic [IN_W-1:0]      R4,
    input  logic [IN_W-1:0]      R5,
    input  logic [IN_W-1:0]      R6,
    output logic [2*OUT_W-1:0]   sonar12,
    output logic [2*OUT_W-1:0]   sonar34,
    output logic [2*OUT_W-1:0]   sonar56,
    output logic [5:0]           upd,
    output logic                 sweep_done,
    output logic                 busy
);

    typedef enum logic [1:0] {LOAD, DIV, STORE} state_t;

    localparam int CW = $clog2(IN_W + 1);
    localparam logic [IN_W:0]   DIV_V = (IN_W + 1)'(DIVISOR);
    localparam logic [IN_W-1:0] QMAX  = IN_W'((1 << OUT_W) - 1);

    state_t                    state_q, state_d;
    logic [2:0]                ch_q, ch_d;
    logic [IN_W-1:0]           dvd_q, dvd_d;
    logic [IN_W:0]             rem_q, rem_d;
    logic [IN_W-1:0]           quo_q, quo_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [5:0][OUT_W-1:0]     dist_q, dist_d;
    logic [5:0]                upd_q, upd_d;
    logic                      done_q, done_d;
    logic                      busy_q, busy_d;

    logic [IN_W-1:0]           r_sel;
    logic [IN_W:0]             rem_sh;
    logic                      ge;
    logic [OUT_W-1:0]          q_sat;

    always_comb begin
        r_sel = '0;
        unique case (ch_q)
            3'd0:    r_sel = R1;
            3'd1:    r_sel = R2;
            3'd2:    r_sel = R3;
            3'd3:    r_sel = R4;
            3'd4:    r_sel = R5;
            3'd5:    r_sel = R6;
            default: r_sel = '0;
        endcase
    end

    // Remainder stays below DIVISOR, so the shifted value fits IN_W+1 bits.
    assign rem_sh = {rem_q[IN_W-1:0], dvd_q[IN_W-1]};
    assign ge     = (rem_sh >= DIV_V);
    assign q_sat  = (quo_q > QMAX) ? QMAX[OUT_W-1:0] : quo_q[OUT_W-1:0];

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        dist_d  = dist_q;
        upd_d   = '0;
        done_d  = 1'b0;
        case (state_q)
            LOAD: begin
                if (en) begin
                    dvd_d   = r_sel;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                rem_d = ge ? (rem_sh - DIV_V) : rem_sh;
                quo_d = {quo_q[IN_W-2:0], ge};
                dvd_d = {dvd_q[IN_W-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(IN_W - 1)) begin
                    state_d = STORE;
                end
            end
            STORE: begin
                for (int k = 0; k < 6; k++) begin
                    if (ch_q == 3'(k)) begin
                        dist_d[k] = q_sat;
                        upd_d[k]  = 1'b1;
                    end
                end
                done_d  = (ch_q == 3'd5);
                ch_d    = (ch_q == 3'd5) ? 3'd0 : ch_q + 3'd1;
                state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
        busy_d = (state_d != LOAD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD;
            ch_q    <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            dist_q  <= '0;
            upd_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            dist_q  <= dist_d;
            upd_q   <= upd_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign sonar12    = {dist_q[0], dist_q[1]};
    assign sonar34    = {dist_q[2], dist_q[3]};
    assign sonar56    = {dist_q[4], dist_q[5]};
    assign upd        = upd_q;
    assign sweep_done = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sonar_range.sv
// Directed bench for sonar_range: timing of upd pulses, saturation,
// input sampling, reset abort and en drop behaviour.
module tb_sonar_range;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [19:0] R1, R2, R3, R4, R5, R6;
    logic [15:0] sonar12, sonar34, sonar56;
    logic [5:0]  upd;
    logic        sweep_done;
    logic        busy;

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;

    sonar_range dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .R1         (R1),
        .R2         (R2),
        .R3         (R3),
        .R4         (R4),
        .R5         (R5),
        .R6         (R6),
        .sonar12    (sonar12),
        .sonar34    (sonar34),
        .sonar56    (sonar56),
        .upd        (upd),
        .sweep_done (sweep_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Assert reset, then release on a falling edge; cycle 1 is the next rise.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
    endtask

    function automatic logic [7:0] model(input logic [19:0] r);
        int q;
        q = int'(r) / 2941;
        return (q > 255) ? 8'd255 : 8'(q);
    endfunction

    // Walk n cycles checking upd/sweep_done against the 22-cycle schedule.
    task automatic sweep_sched(input int base, input int n);
        logic [5:0] eu;
        int         rel;
        for (int i = 0; i < n; i++) begin
            tick();
            rel = cyc - base;
            eu  = '0;
            if (rel % 22 == 0) eu = 6'(1 << ((rel / 22 - 1) % 6));
            chk("upd_sched", 32'(upd), 32'(eu));
            chk("done_sched", 32'(sweep_done),
                32'(rel % 132 == 0));
        end
    endtask

    initial begin
        logic [19:0] rv [6];
        logic [7:0]  e1, e2, e3, e4, e5, e6;
        int          guard;

        reset = 1'b0;
        en    = 1'b0;
        R1 = 20'd0; R2 = 20'd2940; R3 = 20'd2941;
        R4 = 20'd29410; R5 = 20'd749955; R6 = 20'd1048575;
        #12;
        chk("rst_s12", 32'(sonar12), 32'h0);
        chk("rst_s34", 32'(sonar34), 32'h0);
        chk("rst_s56", 32'(sonar56), 32'h0);
        chk("rst_upd", 32'(upd), 32'h0);
        chk("rst_done", 32'(sweep_done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Two full sweeps of directed values with schedule checking.
        en = 1'b1;
        do_reset();
        sweep_sched(0, 132);
        chk("s12", 32'(sonar12), 32'h0000);
        chk("s34", 32'(sonar34), 32'h010A);
        chk("s56", 32'(sonar56), 32'hFFFF);
        sweep_sched(0, 132);
        chk("s34_2", 32'(sonar34), 32'h010A);

        // R1 change during DIV must not affect the current result.
        R1 = 20'd5882;
        do_reset();
        tick(); tick(); tick();
        chk("busy_div", 32'(busy), 32'h1);
        R1 = 20'd8823;
        while (cyc < 22) tick();
        chk("r1_upd", 32'(upd), 32'h01);
        chk("r1_first", 32'(sonar12[15:8]), 32'd2);
        while (cyc < 154) tick();
        chk("r1_upd2", 32'(upd), 32'h01);
        chk("r1_second", 32'(sonar12[15:8]), 32'd3);

        // Reset in the middle of channel 3 division.
        R1 = 20'd29410; R2 = 20'd29410;
        do_reset();
        while (cyc < 44) tick();
        chk("pre_s12", 32'(sonar12), 32'h0A0A);
        while (cyc < 55) tick();
        chk("mid_busy", 32'(busy), 32'h1);
        reset = 1'b0;
        #1;
        chk("ar_s12", 32'(sonar12), 32'h0);
        chk("ar_s34", 32'(sonar34), 32'h0);
        chk("ar_s56", 32'(sonar56), 32'h0);
        chk("ar_upd", 32'(upd), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        for (int i = 0; i < 22; i++) begin
            tick();
            chk("restart_upd", 32'(upd), (cyc == 22) ? 32'h01 : 32'h0);
        end
        chk("restart_s34", 32'(sonar34), 32'h0);

        // Drop en during channel 2 DIV; channel completes, then idles.
        do_reset();
        while (cyc < 30) tick();
        en = 1'b0;
        while (cyc < 44) tick();
        chk("en_upd1", 32'(upd), 32'h02);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("idle_busy", 32'(busy), 32'h0);
            chk("idle_upd", 32'(upd), 32'h0);
        end
        en = 1'b1;
        guard = cyc;
        for (int i = 0; i < 22; i++) tick();
        chk("en_upd2", 32'(upd), 32'h04);
        chk("en_ch3_cyc", 32'(cyc - guard), 32'd22);

        // Random sweeps against the reference division.
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 6; k++) rv[k] = 20'($urandom);
            rv[s] = (s == 0) ? 20'd752895 : (s == 1) ? 20'd752896 :
                    (s == 2) ? 20'd5881 : 20'd5882;
            R1 = rv[0]; R2 = rv[1]; R3 = rv[2];
            R4 = rv[3]; R5 = rv[4]; R6 = rv[5];
            do_reset();
            guard = 0;
            while (!sweep_done && guard < 200) begin
                tick();
                guard++;
            end
            chk("rnd_timeout", 32'(guard < 200), 32'h1);
            e1 = model(rv[0]); e2 = model(rv[1]); e3 = model(rv[2]);
            e4 = model(rv[3]); e5 = model(rv[4]); e6 = model(rv[5]);
            chk("rnd_s12", 32'(sonar12), 32'({e1, e2}));
            chk("rnd_s34", 32'(sonar34), 32'({e3, e4}));
            chk("rnd_s56", 32'(sonar56), 32'({e5, e6}));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/sonar_range.md
SONAR_RANGE -- requirements
Module: sonar_range

Interface
REQ-001 Parameter IN_W, default 20, width of each raw sonar echo count.
REQ-002 Parameter DIVISOR, default 2941, number of clk cycles per distance unit; legal range 1..2^IN_W-1.
REQ-003 Parameter OUT_W, default 8, width of each distance result.
REQ-004 clk  in  1  system clock (CLOCK_50 domain); all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-006 en  in  1  conversion enable; level-sensitive.
REQ-007 R1..R6  in  IN_W each  raw echo counts from the front and back sonar blocks; treated as quasi-static.
REQ-008 sonar12, sonar34, sonar56  out  2*OUT_W each  packed distances {dist1,dist2}, {dist3,dist4}, {dist5,dist6}.
REQ-009 upd  out  6  one-cycle pulse; bit k-1 marks a new dist_k written this cycle.
REQ-010 sweep_done  out  1  one-cycle pulse when channel 6 result is written.
REQ-011 busy  out  1  high in DIV and STORE states.

Function
REQ-012 The block SHALL replace six combinational dividers with one shared sequential restoring divider serving channels 1..6 round-robin.
REQ-013 FSM states: LOAD, DIV, STORE; channel index ch in 0..5.
REQ-014 LOAD: if en=1, capture R[ch+1] into dividend, clear remainder, quotient and bit counter, go to DIV; if en=0, stay in LOAD, capture nothing.
REQ-015 DIV: exactly IN_W cycles, one quotient bit per cycle, MSB first: rem' = {rem,dividend MSB}; if rem' >= DIVISOR then subtract and shift in 1, else shift in 0.
REQ-016 Remainder register SHALL be IN_W+1 bits; quotient register IN_W bits; no overflow permitted for any legal DIVISOR.
REQ-017 After the IN_W-th DIV cycle go to STORE.
REQ-018 STORE: dist[ch] <= quotient if quotient <= 2^OUT_W-1, else 2^OUT_W-1 (saturate); pulse upd[ch]; ch <= (ch==5) ? 0 : ch+1; go to LOAD.
REQ-019 sweep_done SHALL pulse in the same cycle as upd[5].
REQ-020 Latency per channel = IN_W+2 cycles (132 cycles per full sweep at defaults, en held high).
REQ-021 R inputs SHALL be sampled only in LOAD; changes during DIV/STORE do not affect the current result.
REQ-022 en deasserted during DIV/STORE SHALL NOT abort; the channel completes and the FSM then waits in LOAD.
REQ-023 Distance registers SHALL hold their last value between updates; outputs are registered, no combinational path from R to outputs.
REQ-024 Result SHALL equal floor(R/DIVISOR) saturated, bit-exact with the combinational division it replaces.

Reset
REQ-025 On reset=0, immediately: all dist registers 0, upd 0, sweep_done 0, busy 0, ch 0, state LOAD, divider registers 0.
REQ-026 Reset asserted mid-division SHALL discard the partial result; no upd pulse is produced for that channel.
REQ-027 After reset release with en=1, first capture is channel 1 on the first clk edge; upd[0] pulses IN_W+2 cycles after release.

Verification
REQ-028 R1=0, R2=2940, R3=2941, R4=29410, R5=749955, R6=1048575, en=1 -> dist1..6 = 0, 0, 1, 10, 255, 255 (saturated); sonar12=16'h0000, sonar34=16'h010A, sonar56=16'hFFFF.
REQ-029 en=1 from reset release -> upd pulses 000001, 000010, ... 100000 at cycles 22, 44, ..., 132, sweep_done with upd[5]; repeats every 132 cycles.
REQ-030 R1=5882 held, change R1 to 8823 two cycles after channel 1 LOAD -> dist1=2 this sweep, 3 next sweep.
REQ-031 Assert reset at cycle 10 of channel 3 DIV -> all outputs 0 immediately, no upd[2]; after release conversion restarts at channel 1.
REQ-032 Drop en mid-DIV of channel 2 -> upd[1] still pulses, FSM then idles in LOAD with busy=0, ch=2; raise en -> channel 3 converts next.
REQ-033 Random R values, 10k sweeps -> every dist_k matches min(floor(R_k/2941),255) captured at its LOAD cycle.
